// File: rtl/instr_decoder.sv
// Instruction decoder with a one-deep valid/ready output register, halt/trap FSM and retired counter.
// Optional feature: define DECODER_TRAP_EN to trap on illegal opcodes instead of dropping them.
module instr_decoder #(
  parameter int B     = 8,
  parameter int OP_B  = 4,
  parameter int R_B   = 2,
  parameter int CNT_B = 16,
  localparam int IW   = OP_B + 2*R_B + B
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IW-1:0]    in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_op,
  output logic             use_imm,
  output logic             reg_we,
  output logic [R_B-1:0]   rd,
  output logic [R_B-1:0]   rs,
  output logic [B-1:0]     imm,
  output logic             halted,
  output logic             trap,
  output logic [CNT_B-1:0] retired
);

  typedef enum logic [1:0] {RUN, HALTED, TRAP} state_t;

  localparam logic [OP_B-1:0] OP_NOP  = OP_B'(0);
  localparam logic [OP_B-1:0] OP_HALT = OP_B'(1);
  localparam logic [OP_B-1:0] OP_SET  = OP_B'(2);
  localparam logic [OP_B-1:0] OP_COPY = OP_B'(3);
  localparam logic [OP_B-1:0] OP_ADDR = OP_B'(4);
  localparam logic [OP_B-1:0] OP_ADDV = OP_B'(5);
  localparam logic [OP_B-1:0] OP_SUBR = OP_B'(6);
  localparam logic [OP_B-1:0] OP_SUBV = OP_B'(7);
  localparam logic [OP_B-1:0] OP_ANDR = OP_B'(8);
  localparam logic [OP_B-1:0] OP_ORR  = OP_B'(9);
  localparam logic [OP_B-1:0] OP_XORR = OP_B'(10);
  localparam logic [OP_B-1:0] OP_SHLV = OP_B'(11);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;

  // Returns {alu_op, use_imm, reg_we} for a legal, issuing opcode.
  function automatic logic [4:0] decode(input logic [OP_B-1:0] op);
    case (op)
      OP_SET:  return {ALU_PASS, 1'b1, 1'b1};
      OP_COPY: return {ALU_PASS, 1'b0, 1'b1};
      OP_ADDR: return {ALU_ADD,  1'b0, 1'b1};
      OP_ADDV: return {ALU_ADD,  1'b1, 1'b1};
      OP_SUBR: return {ALU_SUB,  1'b0, 1'b1};
      OP_SUBV: return {ALU_SUB,  1'b1, 1'b1};
      OP_ANDR: return {ALU_AND,  1'b0, 1'b1};
      OP_ORR:  return {ALU_OR,   1'b0, 1'b1};
      OP_XORR: return {ALU_XOR,  1'b0, 1'b1};
      OP_SHLV: return {ALU_SHL,  1'b1, 1'b1};
      default: return {ALU_PASS, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic [CNT_B-1:0] sat_inc(input logic [CNT_B-1:0] v);
    return (v == {CNT_B{1'b1}}) ? v : v + CNT_B'(1);
  endfunction

  state_t state, state_nx;

  logic [OP_B-1:0]  op_p0;
  logic [R_B-1:0]   rd_p0, rs_p0;
  logic [B-1:0]     imm_p0;
  logic             accept_p0, legal_p0, issue_p0;
  logic [4:0]       dec_p0;

  logic             vld_p1;
  logic [2:0]       alu_op_p1;
  logic             use_imm_p1, reg_we_p1;
  logic [R_B-1:0]   rd_p1, rs_p1;
  logic [B-1:0]     imm_p1;
  logic [CNT_B-1:0] retired_p1;

  assign op_p0  = in_instr[IW-1 -: OP_B];
  assign rd_p0  = in_instr[IW-1-OP_B -: R_B];
  assign rs_p0  = in_instr[IW-1-OP_B-R_B -: R_B];
  assign imm_p0 = in_instr[B-1:0];
  assign dec_p0 = decode(op_p0);

  always_comb begin
    in_ready  = (state == RUN) && (!vld_p1 || out_ready);
    accept_p0 = in_valid && in_ready;
    legal_p0  = (op_p0 <= OP_SHLV);
    // halt and illegal opcodes are consumed without producing a micro-op
    issue_p0  = accept_p0 && legal_p0 && (op_p0 != OP_HALT);
    state_nx  = state;
    case (state)
      RUN: begin
        if (accept_p0 && op_p0 == OP_HALT) begin
          state_nx = HALTED;
        end
`ifdef DECODER_TRAP_EN
        else if (accept_p0 && !legal_p0) begin
          state_nx = TRAP;
        end
`endif
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      alu_op_p1  <= '0;
      use_imm_p1 <= 1'b0;
      reg_we_p1  <= 1'b0;
      rd_p1      <= '0;
      rs_p1      <= '0;
      imm_p1     <= '0;
      retired_p1 <= '0;
    end else begin
      vld_p1 <= issue_p0 || (vld_p1 && !out_ready);
      if (issue_p0) begin
        alu_op_p1  <= dec_p0[4:2];
        use_imm_p1 <= dec_p0[1];
        reg_we_p1  <= dec_p0[0];
        rd_p1      <= rd_p0;
        rs_p1      <= rs_p0;
        imm_p1     <= imm_p0;
      end
      if (vld_p1 && out_ready) begin
        retired_p1 <= sat_inc(retired_p1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign alu_op    = alu_op_p1;
  assign use_imm   = use_imm_p1;
  assign reg_we    = reg_we_p1;
  assign rd        = rd_p1;
  assign rs        = rs_p1;
  assign imm       = imm_p1;
  assign retired   = retired_p1;
  assign halted    = (state == HALTED);
`ifdef DECODER_TRAP_EN
  assign trap      = (state == TRAP);
`else
  assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: handshake, decode, halt, illegal opcode, counter saturation, reset.
module tb_instr_decoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, use_imm, reg_we, halted, trap;
  logic [2:0]  alu_op;
  logic [1:0]  rd, rs;
  logic [7:0]  imm;
  logic [15:0] retired;

  logic [15:0] sm_in_instr = '0;
  logic        sm_in_valid = 1'b0, sm_out_ready = 1'b0;
  logic        sm_in_ready, sm_out_valid, sm_use_imm, sm_reg_we, sm_halted, sm_trap;
  logic [2:0]  sm_alu_op;
  logic [1:0]  sm_rd, sm_rs;
  logic [7:0]  sm_imm;
  logic [1:0]  sm_retired;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  instr_decoder #(.B(8), .OP_B(4), .R_B(2), .CNT_B(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .use_imm(use_imm), .reg_we(reg_we), .rd(rd), .rs(rs),
    .imm(imm), .halted(halted), .trap(trap), .retired(retired)
  );

  instr_decoder #(.B(8), .OP_B(4), .R_B(2), .CNT_B(2)) u_small (
    .clock(clock), .reset_n(reset_n), .in_instr(sm_in_instr), .in_valid(sm_in_valid),
    .in_ready(sm_in_ready), .out_valid(sm_out_valid), .out_ready(sm_out_ready),
    .alu_op(sm_alu_op), .use_imm(sm_use_imm), .reg_we(sm_reg_we), .rd(sm_rd), .rs(sm_rs),
    .imm(sm_imm), .halted(sm_halted), .trap(sm_trap), .retired(sm_retired)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int d, input int s, input int im);
    logic [3:0] o4 = op[3:0];
    logic [1:0] d2 = d[1:0];
    logic [1:0] s2 = s[1:0];
    logic [7:0] i8 = im[7:0];
    return {o4, d2, s2, i8};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    sm_in_valid = 1'b0; sm_out_ready = 1'b0; sm_in_instr = '0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_flags", {use_imm, reg_we, halted, trap}, 0);
    chk("rst_fields", {rd, rs, imm}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // addv rd=1 imm=5
    in_instr = mk(5, 1, 0, 8'h05); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("addv_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("addv_out_valid", out_valid, 1);
    chk("addv_decode", {alu_op, use_imm, reg_we}, {3'd0, 1'b1, 1'b1});
    chk("addv_rd_imm", {rd, imm}, {2'd1, 8'h05});
    step();
    chk("addv_retired", retired, 1);
    chk("addv_drained", out_valid, 0);

    // Four back-to-back subr
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = mk(6, i, 3 - i, 0); in_valid = 1'b1;
      step();
      chk("subr_valid", out_valid, 1);
      chk("subr_decode", {alu_op, use_imm, reg_we, rd, rs}, {3'd1, 1'b0, 1'b1, i[1:0], 2'(3 - i)});
      chk("subr_retired_run", retired, i);
    end
    in_valid = 1'b0;
    step();
    chk("subr_retired", retired, 4);
    chk("subr_idle", out_valid, 0);

    // Backpressure: andr held for 3 cycles while orr waits
    do_reset();
    in_instr = mk(8, 2, 1, 8'h33); in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_instr = mk(9, 3, 2, 8'h44);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", in_ready, 0);
      step();
      chk("stall_hold", {out_valid, alu_op, rd, rs, imm}, {1'b1, 3'd2, 2'd2, 2'd1, 8'h33});
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("release_next", {out_valid, alu_op, rd, imm}, {1'b1, 3'd3, 2'd3, 8'h44});
    chk("release_retired", retired, 1);
    step();
    chk("release_retired2", retired, 2);

    // set, halt, copy
    do_reset();
    out_ready = 1'b1;
    in_instr = mk(2, 1, 0, 8'h7A); in_valid = 1'b1;
    step();
    chk("set_decode", {out_valid, alu_op, use_imm, reg_we, imm}, {1'b1, 3'd6, 1'b1, 1'b1, 8'h7A});
    in_instr = mk(1, 0, 0, 0);
    #1 chk("halt_in_ready", in_ready, 1);
    step();
    chk("halt_no_uop", out_valid, 0);
    chk("halt_flag", halted, 1);
    in_instr = mk(3, 2, 1, 0);
    #1 chk("halted_in_ready", in_ready, 0);
    step(); step();
    chk("halted_no_copy", out_valid, 0);
    chk("halted_retired", retired, 1);

    // Illegal opcode 13
    do_reset();
    chk("halt_cleared", halted, 0);
    out_ready = 1'b1;
    in_instr = mk(13, 1, 1, 8'hFF); in_valid = 1'b1;
    step();
    chk("ill_no_uop", out_valid, 0);
    in_instr = mk(4, 1, 2, 0);
`ifdef DECODER_TRAP_EN
    chk("ill_trap", trap, 1);
    #1 chk("ill_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    chk("ill_addr_blocked", out_valid, 0);
    step();
    chk("ill_retired", retired, 0);
`else
    chk("ill_trap", trap, 0);
    #1 chk("ill_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("ill_addr", {out_valid, alu_op, use_imm, reg_we, rd, rs}, {1'b1, 3'd0, 1'b0, 1'b1, 2'd1, 2'd2});
    step();
    chk("ill_retired", retired, 1);
`endif

    // Saturating counter with CNT_B=2; nop is issued and counted
    do_reset();
    sm_out_ready = 1'b1;
    sm_in_instr = mk(0, 3, 2, 8'h11); sm_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nop_decode", {sm_out_valid, sm_alu_op, sm_use_imm, sm_reg_we}, {1'b1, 3'd6, 1'b0, 1'b0});
    end
    sm_in_valid = 1'b0;
    step();
    chk("sat_retired", sm_retired, 3);
    sm_out_ready = 1'b0; sm_in_valid = 1'b1;
    sm_in_instr = mk(10, 2, 1, 8'h5C);
    step();
    chk("stall_before_rst", {sm_out_valid, sm_alu_op}, {1'b1, 3'd4});
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", sm_out_valid, 0);
    chk("async_rst_fields", {sm_alu_op, sm_use_imm, sm_reg_we, sm_rd, sm_rs, sm_imm}, 0);
    chk("async_rst_retired", sm_retired, 0);
    chk("async_rst_flags", {sm_halted, sm_trap}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("first_after_rst", {sm_out_valid, sm_alu_op, sm_rd, sm_imm}, {1'b1, 3'd4, 2'd2, 8'h5C});
    sm_in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 Parameter B, default 8: data/immediate width in bits.
REQ-002 Parameter OP_B, default 4: opcode field width; minimum 4.
REQ-003 Parameter R_B, default 2: register-index field width.
REQ-004 Parameter CNT_B, default 16: retired-instruction counter width.
REQ-005 Derived IW = OP_B+2*R_B+B; fields: op=instr[IW-1-:OP_B], rd=next R_B bits, rs=next R_B bits, imm=instr[B-1:0].
REQ-006 Ports (clock and reset first) SHALL be as follows; one clock, reset asynchronous and active-low:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_instr  in  IW  instruction word.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  decoder accepts in_instr this cycle.
- out_valid  out  1  decoded micro-op held on outputs.
- out_ready  in  1  consumer takes micro-op this cycle.
- alu_op  out  3  0=add,1=sub,2=and,3=or,4=xor,5=shl,6=pass.
- use_imm  out  1  operand B is imm, not register rs.
- reg_we  out  1  write result to rd.
- rd, rs  out  R_B each  register indices.
- imm  out  B  immediate.
- halted  out  1  halt executed.
- trap  out  1  illegal opcode trapped (TRAP_EN only).
- retired  out  CNT_B  count of micro-ops issued.

Function
REQ-007 Opcodes: 0 nop, 1 halt, 2 set, 3 copy, 4 addr, 5 addv, 6 subr, 7 subv, 8 andr, 9 orr, 10 xorr, 11 shlv; 12..2^OP_B-1 illegal.
REQ-008 Decode: set->pass,use_imm=1,we=1; copy->pass,use_imm=0,we=1; addr/addv->add; subr/subv->sub; andr->and; orr->or; xorr->xor; shlv->shl,use_imm=1; "v" forms use_imm=1, "r" forms use_imm=0; all ALU ops we=1; nop->pass,we=0,use_imm=0.
REQ-009 FSM states RUN, HALTED, TRAP; reset enters RUN.
REQ-010 in_ready = (state==RUN) && (!out_valid || out_ready), combinational.
REQ-011 Transfer when in_valid&&in_ready; micro-op registered, out_valid=1 on the next cycle (latency 1).
REQ-012 Output register holds all fields stable while out_valid&&!out_ready.
REQ-013 out_valid clears after out_ready with no new transfer in the same cycle; a simultaneous drain and accept keeps out_valid=1 with new contents (full throughput, one per cycle).
REQ-014 Halt accepted: no micro-op issued; state->HALTED next cycle; halted=1; in_ready=0 until reset; any pending micro-op still drains normally.
REQ-015 retired increments by 1 on each out_valid&&out_ready, saturating at 2^CNT_B-1 (no wrap).
REQ-016 nop is issued as a micro-op and counted.

Reset
REQ-017 reset_n low asynchronously forces state=RUN, out_valid=0, halted=0, trap=0, retired=0, alu_op=0, use_imm=0, reg_we=0, rd=0, rs=0, imm=0.
REQ-018 Reset asserted mid-handshake discards the pending micro-op; the first transfer is possible on the first rising edge after release.

Configuration
REQ-019 Macro DECODER_TRAP_EN defined: illegal opcode accepted -> no micro-op, state->TRAP, trap=1, in_ready=0 until reset.
REQ-020 DECODER_TRAP_EN undefined: illegal opcode accepted and silently dropped (no micro-op, no count), state stays RUN, trap tied 0.

Verification
REQ-021 Reset, then addv rd=1 imm=0x05 with out_ready=1 -> next cycle out_valid=1, alu_op=0, use_imm=1, reg_we=1, rd=1, imm=0x05; retired=1.
REQ-022 Stream of 4 subr with out_ready=1 every cycle -> 4 micro-ops on 4 consecutive cycles, alu_op=1, use_imm=0, retired=4.
REQ-023 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and output stable; release -> one micro-op per cycle resumes.
REQ-024 set then halt then copy -> only set issued; halted=1; copy never accepted; retired=1.
REQ-025 Opcode 13: with DECODER_TRAP_EN -> trap=1, in_ready=0; without -> dropped, next addr issued normally.
REQ-026 CNT_B=2, 5 nops drained -> retired saturates at 3; reset_n pulse mid-stall -> all outputs at reset values immediately.
